// File: rtl/dual_port_tpram_if.sv
// Signal bundle for the two independent ports of dual_port_tpram.
// The master modport drives the ports; the slave modport is the RAM side.
interface dual_port_tpram_if #(
  parameter int aw = 5,
  parameter int dw = 16
) ();
  logic          ce_a;
  logic          we_a;
  logic          oe_a;
  logic [aw-1:0] addr_a;
  logic [dw-1:0] di_a;
  logic [dw-1:0] do_a;

  logic          ce_b;
  logic          we_b;
  logic          oe_b;
  logic [aw-1:0] addr_b;
  logic [dw-1:0] di_b;
  logic [dw-1:0] do_b;

  modport master (
    output ce_a, we_a, oe_a, addr_a, di_a,
    output ce_b, we_b, oe_b, addr_b, di_b,
    input  do_a, do_b
  );

  modport slave (
    input  ce_a, we_a, oe_a, addr_a, di_a,
    input  ce_b, we_b, oe_b, addr_b, di_b,
    output do_a, do_b
  );
endinterface

// File: rtl/dual_port_tpram.sv
// Two-port synchronous RAM (2^aw x dw), registered reads, port A wins write collisions.
// Define TPRAM_WRITE_THROUGH_EN for write-first same-port behaviour (default read-first).
module dual_port_tpram #(
  parameter int aw = 5,
  parameter int dw = 16
) (
  input  logic               clk,
  input  logic               rst,
  dual_port_tpram_if.slave   bus
);
  localparam int depth = 1 << aw;

  logic [dw-1:0] mem [depth];
  logic [dw-1:0] dout_a_d, dout_a_q;
  logic [dw-1:0] dout_b_d, dout_b_q;
  logic          wr_a, wr_b;

  // B's write is dropped when A writes the same word, so no mixed data lands.
  assign wr_a = bus.ce_a & bus.we_a;
  assign wr_b = bus.ce_b & bus.we_b & ~(wr_a & (bus.addr_a == bus.addr_b));

  always_ff @(posedge clk) begin
    if (wr_a) mem[bus.addr_a] <= bus.di_a;
    if (wr_b) mem[bus.addr_b] <= bus.di_b;
  end

  always_comb begin
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    if (bus.ce_a) begin
`ifdef TPRAM_WRITE_THROUGH_EN
      dout_a_d = bus.we_a ? bus.di_a : mem[bus.addr_a];
`else
      dout_a_d = mem[bus.addr_a];
`endif
    end
    if (bus.ce_b) begin
`ifdef TPRAM_WRITE_THROUGH_EN
      dout_b_d = bus.we_b ? bus.di_b : mem[bus.addr_b];
`else
      dout_b_d = mem[bus.addr_b];
`endif
    end
  end

  // Reset clears only the output registers; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign bus.do_a = bus.oe_a ? dout_a_q : '0;
  assign bus.do_b = bus.oe_b ? dout_b_q : '0;
endmodule

// File: tb/tb_dual_port_tpram.sv
// Directed self-checking bench for dual_port_tpram at the decoder geometry (aw=11, dw=8).
module tb_dual_port_tpram;
  localparam int aw = 11;
  localparam int dw = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  dual_port_tpram_if #(.aw(aw), .dw(dw)) bus ();

  dual_port_tpram #(.aw(aw), .dw(dw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [dw-1:0] obs, input logic [dw-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ce_a = 1'b0; bus.we_a = 1'b0;
    bus.ce_b = 1'b0; bus.we_b = 1'b0;
  endtask

  initial begin
    logic [dw-1:0] wt_a_exp;
    logic [dw-1:0] wt_b_exp;
    tests = 0;
    fails = 0;

    rst = 1'b0;
    bus.ce_a = 1'b0; bus.we_a = 1'b0; bus.oe_a = 1'b1; bus.addr_a = '0; bus.di_a = '0;
    bus.ce_b = 1'b0; bus.we_b = 1'b0; bus.oe_b = 1'b1; bus.addr_b = '0; bus.di_b = '0;
    step();
    step();
    check("reset_do_a", bus.do_a, 8'h00);
    check("reset_do_b", bus.do_b, 8'h00);
    rst = 1'b1;

    // basic write on A, read back on B
    bus.ce_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 11'h010; bus.di_a = 8'h5A;
    step();
    idle();
    bus.ce_b = 1'b1; bus.addr_b = 11'h010;
    check("b_before_edge", bus.do_b, 8'h00);
    step();
    check("b_read_5a", bus.do_b, 8'h5A);

    // output enable is combinational
    bus.ce_b = 1'b0;
    bus.oe_b = 1'b0;
    #1;
    check("oe_low", bus.do_b, 8'h00);
    bus.oe_b = 1'b1;
    #1;
    check("oe_high", bus.do_b, 8'h5A);

    // chip enable low holds output and blocks writes
    bus.addr_b = 11'h011;
    step();
    check("ce_b_hold", bus.do_b, 8'h5A);
    bus.ce_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 11'h020; bus.di_a = 8'h77;
    step();
    bus.ce_a = 1'b0; bus.we_a = 1'b1; bus.di_a = 8'h99;
    step();
    idle();
    bus.ce_b = 1'b1; bus.addr_b = 11'h020;
    step();
    check("ce_a_no_write", bus.do_b, 8'h77);

`ifdef TPRAM_WRITE_THROUGH_EN
    wt_a_exp = 8'h22;
    wt_b_exp = 8'h33;
`else
    wt_a_exp = 8'h11;
    wt_b_exp = 8'h22;
`endif

    // read-during-write, cross-port and same-port
    idle();
    bus.ce_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 11'h030; bus.di_a = 8'h11;
    step();
    bus.di_a = 8'h22;
    bus.ce_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 11'h030;
    step();
    check("xport_rdw_b_old", bus.do_b, 8'h11);
    check("same_port_rdw_a", bus.do_a, wt_a_exp);
    bus.we_a = 1'b0;
    step();
    check("b_after_write", bus.do_b, 8'h22);
    bus.we_b = 1'b1; bus.di_b = 8'h33;
    step();
    check("same_port_rdw_b", bus.do_b, wt_b_exp);
    check("xport_rdw_a_old", bus.do_a, 8'h22);

    // dual write collision, A wins
    bus.ce_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 11'h040; bus.di_a = 8'hAA;
    bus.ce_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 11'h040; bus.di_b = 8'hBB;
    step();
    bus.we_a = 1'b0; bus.we_b = 1'b0;
    step();
    check("collision_a", bus.do_a, 8'hAA);
    check("collision_b", bus.do_b, 8'hAA);

    // reset clears outputs but a concurrent write still lands
    rst = 1'b0;
    bus.we_a = 1'b1; bus.addr_a = 11'h050; bus.di_a = 8'h5C;
    bus.addr_b = 11'h040;
    step();
    check("rst_prio_a", bus.do_a, 8'h00);
    check("rst_prio_b", bus.do_b, 8'h00);
    rst = 1'b1;
    bus.we_a = 1'b0;
    bus.addr_b = 11'h050;
    step();
    check("write_during_rst", bus.do_b, 8'h5C);

    // address wrap: 2047 then 0
    bus.we_a = 1'b1; bus.addr_a = 11'h7FF; bus.di_a = 8'hE1;
    step();
    bus.addr_a = bus.addr_a + 11'd1; bus.di_a = 8'h1E;
    step();
    bus.we_a = 1'b0; bus.ce_a = 1'b0;
    bus.addr_b = 11'h7FF;
    step();
    check("wrap_top", bus.do_b, 8'hE1);
    bus.addr_b = bus.addr_b + 11'd1;
    step();
    check("wrap_zero", bus.do_b, 8'h1E);

    // full-depth sweep
    idle();
    bus.ce_a = 1'b1; bus.we_a = 1'b1;
    for (int i = 0; i < (1 << aw); i++) begin
      bus.addr_a = i[aw-1:0];
      bus.di_a = i[dw-1:0];
      step();
    end
    idle();
    bus.ce_b = 1'b1;
    for (int i = 0; i < (1 << aw); i++) begin
      bus.addr_b = i[aw-1:0];
      step();
      check("sweep", bus.do_b, i[dw-1:0]);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
